// File: rtl/parallel_io_mm.sv
// Memory-mapped parallel I/O: registered output channels, synchronised input
// channels, change flags (write-1-to-clear), a mask register and an interrupt line.
// Decodes the CPU data address and steers stores away from the RAM on I/O hits.
module parallel_io_mm #(
    parameter int unsigned        DATA_W      = 8,
    parameter int unsigned        ADDR_W      = 8,
    parameter int unsigned        N_OUT       = 2,
    parameter int unsigned        N_IN        = 2,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0]  BASE_OUT    = 8'hF0,
    parameter logic [ADDR_W-1:0]  BASE_IN     = 8'hF8,
    parameter logic [ADDR_W-1:0]  STAT_ADDR   = 8'hFE,
    parameter logic [DATA_W-1:0]  OUT_RESET   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    we,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    ram_wren,
    input  logic [N_IN*DATA_W-1:0]  pin_in,
    output logic [N_OUT*DATA_W-1:0] pin_out,
    output logic                    chg_irq
);

    // Address map in plain 32-bit arithmetic so range ends never wrap.
    localparam int unsigned OUT_LO    = 32'(BASE_OUT);
    localparam int unsigned OUT_HI    = OUT_LO + N_OUT;
    localparam int unsigned IN_LO     = 32'(BASE_IN);
    localparam int unsigned IN_HI     = IN_LO + N_IN;
    localparam int unsigned STAT_A    = 32'(STAT_ADDR);
    localparam int unsigned MASK_A    = STAT_A + 1;
    localparam int unsigned ADDR_SPAN = 32'(1) << ADDR_W;

    localparam bit OVERLAP =
        (OUT_LO < IN_HI && IN_LO < OUT_HI) ||
        (OUT_LO <= STAT_A && STAT_A < OUT_HI) || (OUT_LO <= MASK_A && MASK_A < OUT_HI) ||
        (IN_LO <= STAT_A && STAT_A < IN_HI) || (IN_LO <= MASK_A && MASK_A < IN_HI);

    if (N_OUT < 1 || N_OUT > 8) begin : g_bad_n_out
        $error("parallel_io_mm: N_OUT must be 1..8");
    end
    if (N_IN < 1 || N_IN > DATA_W) begin : g_bad_n_in
        $error("parallel_io_mm: N_IN must be 1..DATA_W");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("parallel_io_mm: SYNC_STAGES must be 2..3");
    end
    if (OUT_HI > ADDR_SPAN || IN_HI > ADDR_SPAN || MASK_A >= ADDR_SPAN) begin : g_bad_fit
        $error("parallel_io_mm: I/O ranges must fit below 2^ADDR_W");
    end
    if (OVERLAP) begin : g_bad_overlap
        $error("parallel_io_mm: I/O address ranges overlap");
    end

    logic [31:0]                          addr_u;
    logic [N_OUT-1:0]                     out_sel;
    logic [N_IN-1:0]                      in_sel;
    logic                                 hit_out, hit_in, hit_stat, hit_mask, io;
    logic [SYNC_STAGES-1:0][N_IN*DATA_W-1:0] sync_q;
    logic [N_IN*DATA_W-1:0]               in_sync, in_prev_q;
    logic [N_IN-1:0]                      chg, clr, flag_q, flag_d, mask_q, mask_d;

    assign addr_u  = 32'(address);
    assign in_sync = sync_q[SYNC_STAGES-1];

    // Per-channel one-hot decode of the output and input windows.
    always_comb begin
        for (int i = 0; i < N_OUT; i++) out_sel[i] = (addr_u == OUT_LO + 32'(i));
        for (int i = 0; i < N_IN; i++)  in_sel[i]  = (addr_u == IN_LO + 32'(i));
    end

    assign hit_out  = |out_sel;
    assign hit_in   = |in_sel;
    assign hit_stat = (addr_u == STAT_A);
    assign hit_mask = (addr_u == MASK_A);
    assign io       = hit_out | hit_in | hit_stat | hit_mask;
    assign ram_wren = we & ~io;

    // Load data mux: I/O windows take priority over RAM data.
    always_comb begin
        rdata = mem_rdata;
        if (hit_out) begin
            rdata = '0;
            for (int i = 0; i < N_OUT; i++)
                if (out_sel[i]) rdata = pin_out[i*DATA_W +: DATA_W];
        end else if (hit_in) begin
            rdata = '0;
            for (int i = 0; i < N_IN; i++)
                if (in_sel[i]) rdata = in_sync[i*DATA_W +: DATA_W];
        end else if (hit_stat) begin
            rdata = DATA_W'(flag_q);
        end else if (hit_mask) begin
            rdata = DATA_W'(mask_q);
        end
    end

    // Output channel registers; only the addressed channel is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_out <= {N_OUT{OUT_RESET}};
        end else if (we) begin
            for (int i = 0; i < N_OUT; i++)
                if (out_sel[i]) pin_out[i*DATA_W +: DATA_W] <= wdata;
        end
    end

    // Input synchroniser chain plus one-cycle-old copy for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            in_prev_q <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            in_prev_q <= in_sync;
        end
    end

    // Flag/mask next state; a new change wins over a same-cycle clear.
    always_comb begin
        for (int i = 0; i < N_IN; i++)
            chg[i] = (in_sync[i*DATA_W +: DATA_W] != in_prev_q[i*DATA_W +: DATA_W]);
        clr    = (we && hit_stat) ? wdata[N_IN-1:0] : '0;
        flag_d = (flag_q & ~clr) | chg;
        mask_d = (we && hit_mask) ? wdata[N_IN-1:0] : mask_q;
    end

    // Status registers; the interrupt tracks the post-edge flag and mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q  <= '0;
            mask_q  <= '0;
            chg_irq <= 1'b0;
        end else begin
            flag_q  <= flag_d;
            mask_q  <= mask_d;
            chg_irq <= |(flag_d & mask_d);
        end
    end

endmodule

// File: tb/tb_parallel_io_mm.sv
// Self-checking bench for parallel_io_mm: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_parallel_io_mm;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  address, wdata, mem_rdata, rdata;
    logic        we, ram_wren, chg_irq;
    logic [15:0] pin_in, pin_out;

    int n_vec = 0;
    int n_err = 0;

    parallel_io_mm dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .wdata     (wdata),
        .we        (we),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .ram_wren  (ram_wren),
        .pin_in    (pin_in),
        .pin_out   (pin_out),
        .chg_irq   (chg_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wd;
        logic [7:0]  mem;
        logic [7:0]  exp_rd;
        logic        exp_wren;
        logic [15:0] exp_out;
    } vec_t;

    vec_t tbl[12];

    // Behavioural model state: output values, pin history (index 0 = newest sample).
    logic [7:0]  m_out[2];
    logic [15:0] m_hist[$];
    logic [1:0]  m_flag, m_mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        we = 1'b0;
        address = a;
        #1;
        check(name, 32'(rdata), 32'(exp));
    endtask

    function automatic bit m_is_out(input logic [7:0] a);
        return a == 8'hF0 || a == 8'hF1;
    endfunction

    function automatic bit m_is_in(input logic [7:0] a);
        return a == 8'hF8 || a == 8'hF9;
    endfunction

    function automatic bit m_io(input logic [7:0] a);
        return m_is_out(a) || m_is_in(a) || a == 8'hFE || a == 8'hFF;
    endfunction

    function automatic logic [7:0] m_rdata(input logic [7:0] a);
        logic [15:0] s;
        s = m_hist[SYNC-1];
        if (m_is_out(a)) return m_out[int'(a) - 240];
        if (m_is_in(a)) return (a == 8'hF8) ? s[7:0] : s[15:8];
        if (a == 8'hFE) return {6'b0, m_flag};
        if (a == 8'hFF) return {6'b0, m_mask};
        return mem_rdata;
    endfunction

    task automatic m_reset();
        m_hist = {};
        for (int i = 0; i <= SYNC; i++) m_hist.push_back(16'h0);
        m_out[0] = 8'h00;
        m_out[1] = 8'h00;
        m_flag = 2'b00;
        m_mask = 2'b00;
    endtask

    // Model update for one rising edge using the inputs currently applied.
    task automatic m_edge();
        logic [15:0] now_v, old_v;
        now_v = m_hist[SYNC-1];
        old_v = m_hist[SYNC];
        for (int ch = 0; ch < 2; ch++) begin
            if (now_v[ch*8 +: 8] != old_v[ch*8 +: 8]) m_flag[ch] = 1'b1;
            else if (we && address == 8'hFE && wdata[ch]) m_flag[ch] = 1'b0;
        end
        if (we && address == 8'hFF) m_mask = wdata[1:0];
        if (we && m_is_out(address)) m_out[int'(address) - 240] = wdata;
        m_hist.push_front(pin_in);
        void'(m_hist.pop_back());
    endtask

    initial begin
        //          we    addr   wd     mem    exp_rd exp_wren exp_out
        tbl[0]  = '{1'b1, 8'hF1, 8'hA5, 8'h33, 8'h00, 1'b0, 16'hA500};
        tbl[1]  = '{1'b0, 8'hF1, 8'h00, 8'h33, 8'hA5, 1'b0, 16'hA500};
        tbl[2]  = '{1'b1, 8'h10, 8'h77, 8'h5A, 8'h5A, 1'b1, 16'hA500};
        tbl[3]  = '{1'b0, 8'h10, 8'h00, 8'h5A, 8'h5A, 1'b0, 16'hA500};
        tbl[4]  = '{1'b1, 8'hF0, 8'h3C, 8'h00, 8'h00, 1'b0, 16'hA53C};
        tbl[5]  = '{1'b1, 8'hF8, 8'hFF, 8'h11, 8'h00, 1'b0, 16'hA53C};
        tbl[6]  = '{1'b1, 8'hFF, 8'h03, 8'h11, 8'h00, 1'b0, 16'hA53C};
        tbl[7]  = '{1'b0, 8'hFF, 8'h00, 8'h11, 8'h03, 1'b0, 16'hA53C};
        tbl[8]  = '{1'b0, 8'hF2, 8'h00, 8'h99, 8'h99, 1'b0, 16'hA53C};
        tbl[9]  = '{1'b1, 8'hEF, 8'h00, 8'h42, 8'h42, 1'b1, 16'hA53C};
        tbl[10] = '{1'b0, 8'hFE, 8'h00, 8'h42, 8'h00, 1'b0, 16'hA53C};
        tbl[11] = '{1'b0, 8'hFA, 8'h00, 8'h66, 8'h66, 1'b0, 16'hA53C};

        // Reset with channel 1 pins nonzero.
        we = 1'b0; address = 8'h00; wdata = 8'h00; mem_rdata = 8'h00;
        pin_in = 16'h0500; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pin_out", 32'(pin_out), 32'h0);
        check("reset_irq", 32'(chg_irq), 32'h0);
        read_chk("reset_flags", 8'hFE, 8'h00);
        rst = 1'b0;
        repeat (SYNC + 1) tick();
        read_chk("release_flags", 8'hFE, 8'h02);
        check("release_irq_masked", 32'(chg_irq), 32'h0);
        we = 1'b1; address = 8'hFE; wdata = 8'h03;
        tick();
        read_chk("w1c_clear", 8'hFE, 8'h00);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            we = tbl[i].we; address = tbl[i].addr; wdata = tbl[i].wd; mem_rdata = tbl[i].mem;
            #1;
            check($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].exp_rd));
            check($sformatf("tbl%0d_wren", i), 32'(ram_wren), 32'(tbl[i].exp_wren));
            tick();
            check($sformatf("tbl%0d_pin_out", i), 32'(pin_out), 32'(tbl[i].exp_out));
        end
        we = 1'b0;

        // Channel 0 change 00 -> 3C, mask = 03.
        pin_in = 16'h053C;
        tick();
        read_chk("sync_lat1", 8'hF8, 8'h00);
        tick();
        read_chk("sync_lat2", 8'hF8, 8'h3C);
        read_chk("flag_before", 8'hFE, 8'h00);
        check("irq_before", 32'(chg_irq), 32'h0);
        tick();
        read_chk("flag_set", 8'hFE, 8'h01);
        check("irq_set", 32'(chg_irq), 32'h1);
        we = 1'b1; address = 8'hFF; wdata = 8'h00;
        tick();
        we = 1'b0;
        check("irq_mask00", 32'(chg_irq), 32'h0);
        we = 1'b1; address = 8'hFF; wdata = 8'h01;
        tick();
        we = 1'b0;
        check("irq_mask01", 32'(chg_irq), 32'h1);

        // Clear on the same edge as a new change: set wins.
        pin_in = 16'h0511;
        tick();
        tick();
        we = 1'b1; address = 8'hFE; wdata = 8'h01;
        tick();
        read_chk("set_beats_clear", 8'hFE, 8'h01);
        check("set_beats_clear_irq", 32'(chg_irq), 32'h1);
        we = 1'b1; address = 8'hFE; wdata = 8'h01;
        tick();
        read_chk("clear_flag", 8'hFE, 8'h00);
        check("clear_irq", 32'(chg_irq), 32'h0);

        // Reset asserted in the middle of a store.
        we = 1'b1; address = 8'hF0; wdata = 8'h99;
        #2;
        rst = 1'b1;
        #1;
        check("midwrite_reset_out", 32'(pin_out), 32'h0);
        check("midwrite_reset_irq", 32'(chg_irq), 32'h0);
        we = 1'b0;
        tick();
        check("in_reset_out", 32'(pin_out), 32'h0);
        rst = 1'b0;
        tick();
        check("after_release_out", 32'(pin_out), 32'h0);

        // Randomized traffic against the model, from a fresh reset.
        rst = 1'b1;
        pin_in = 16'h0000;
        #1;
        m_reset();
        rst = 1'b0;
        tick();
        m_edge();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) pin_in = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       address = 8'($urandom);
                1:       address = 8'hF0 + 8'($urandom_range(0, 2));
                2:       address = 8'hF8 + 8'($urandom_range(0, 2));
                default: address = 8'hFE + 8'($urandom_range(0, 1));
            endcase
            wdata = 8'($urandom);
            mem_rdata = 8'($urandom);
            #1;
            check("rnd_rdata", 32'(rdata), 32'(m_rdata(address)));
            check("rnd_wren", 32'(ram_wren), 32'(we & ~m_io(address)));
            check("rnd_pin_out", 32'(pin_out), 32'({m_out[1], m_out[0]}));
            check("rnd_irq", 32'(chg_irq), 32'(|(m_flag & m_mask)));
            m_edge();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
